iob_uart_serial_sink: RTL

Simulation/board-side UART line receiver that sits directly downstream of the UART 16550 transmit pad (pad_stx_o).
- Deserialises 8N1 frames into a small FIFO.
- Exposes received bytes, status and a baud divisor through an IOb slave port, so benches and loopback checkers can read what the UART core transmitted.
- Single clock domain; the serial input is treated as asynchronous.

---
 rtl/iob_uart_serial_sink_pkg.sv | 30 +++
 rtl/iob_uart_sink_fifo.sv | 63 ++++++
 rtl/iob_uart_serial_sink.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/iob_uart_serial_sink_pkg.sv
// Shared constants for the UART serial sink: FSM encoding, register map,
// STATUS bit positions and CTRL command bits.
package iob_uart_serial_sink_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int RX_VALID_BIT     = 8;
  localparam int STAT_OVERRUN_BIT = 15;
  localparam int STAT_FERR_BIT    = 14;
  localparam int STAT_BUSY_BIT    = 13;

  localparam int CTRL_CLR_OVERRUN = 0;
  localparam int CTRL_CLR_FERR    = 1;
  localparam int CTRL_FLUSH       = 2;

  // Divisors below 2 would give a zero half-bit count, so clamp them.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/iob_uart_sink_fifo.sv
// Small synchronous FIFO with flush; pop is ignored when empty and a push
// into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module iob_uart_sink_fifo #(
  parameter int FIFO_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [FIFO_W:0]   count_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int DEPTH = 1 << FIFO_W;
  localparam logic [FIFO_W:0] FULL_CNT = {1'b1, {FIFO_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_reg;
  logic [FIFO_W-1:0] rd_ptr_reg;
  logic [FIFO_W:0]   count_reg;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_reg == FULL_CNT);
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign data_o  = mem[rd_ptr_reg];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (cke_i && do_push && !flush_i) begin
      mem[wr_ptr_reg] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (cke_i) begin
      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (do_push && !do_pop) count_reg <= count_reg + 1'b1;
        else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_uart_serial_sink.sv
// 8N1 UART line receiver feeding a small FIFO, with bytes, status and the
// clocks-per-bit divisor exposed through an always-ready IOb slave port.
module iob_uart_serial_sink
  import iob_uart_serial_sink_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int DIV_DEFAULT = 16,
  parameter int FIFO_W      = 3
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                rxd_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o,
  output logic                frame_o
);

  logic        sync1_reg;
  logic        rx_s;
  logic [2:0]  state_reg;
  logic [15:0] cnt_reg;
  logic [15:0] fdiv_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic        push_reg;
  logic        overrun_reg;
  logic        ferr_reg;
  logic [15:0] div_reg;
  logic        rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic        ready_reg;

  logic [1:0]  sel;
  logic        rd_req;
  logic        wr_req;
  logic        ctrl_wr;
  logic        div_wr;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        fifo_full;
  logic        fifo_empty;
  logic [FIFO_W:0] fifo_count;
  logic [7:0]  fifo_data;
  logic [15:0] eff;
  logic        overrun_set;
  logic        ferr_set;
  logic [15:0] rd_val;
  logic        unused_bits;

  assign sel        = iob_addr_i[3:2];
  assign rd_req     = iob_avalid_i && (iob_wstrb_i == '0);
  assign wr_req     = iob_avalid_i && (iob_wstrb_i != '0);
  assign ctrl_wr    = wr_req && (sel == REG_CTRL);
  assign div_wr     = wr_req && (sel == REG_DIV);
  assign fifo_pop   = rd_req && (sel == REG_RXDATA);
  assign fifo_flush = ctrl_wr && iob_wdata_i[CTRL_FLUSH];
  assign eff        = eff_div(div_reg);

  // A full FIFO only overruns when no pop makes room; a flush swallows the byte.
  assign overrun_set = push_reg && fifo_full && !fifo_pop && !fifo_flush;
  assign ferr_set    = (state_reg == ST_STOP) && (cnt_reg == '0) && !rx_s;

  assign iob_ready_o  = ready_reg;
  assign iob_rvalid_o = rvalid_reg;
  assign iob_rdata_o  = rdata_reg;
  assign frame_o      = push_reg;
  assign unused_bits  = &{1'b0, iob_wdata_i, iob_addr_i};

  iob_uart_sink_fifo #(
    .FIFO_W (FIFO_W),
    .DATA_W (8)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .push_i   (push_reg),
    .pop_i    (fifo_pop),
    .flush_i  (fifo_flush),
    .wdata_i  (shift_reg),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count),
    .data_o   (fifo_data)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else if (cke_i) begin
      sync1_reg <= rxd_i;
      rx_s      <= sync1_reg;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      fdiv_reg  <= 16'(DIV_DEFAULT);
      idx_reg   <= '0;
      shift_reg <= '0;
      push_reg  <= 1'b0;
    end else if (cke_i) begin
      push_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // The frame divisor is latched here so DIV writes never affect a frame in flight.
          if (!rx_s) begin
            fdiv_reg  <= eff;
            cnt_reg   <= {1'b0, eff[15:1]} - 16'd1;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else if (!rx_s) begin
            cnt_reg   <= fdiv_reg - 16'd1;
            idx_reg   <= '0;
            state_reg <= ST_DATA;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else begin
            shift_reg[idx_reg] <= rx_s;
            cnt_reg            <= fdiv_reg - 16'd1;
            if (idx_reg == 3'd7) state_reg <= ST_STOP;
            else                 idx_reg   <= idx_reg + 3'd1;
          end
        end
        ST_STOP: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else if (rx_s) begin
            push_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overrun_reg <= 1'b0;
      ferr_reg    <= 1'b0;
      div_reg     <= 16'(DIV_DEFAULT);
    end else if (cke_i) begin
      if (overrun_set)
        overrun_reg <= 1'b1;
      else if (ctrl_wr && iob_wdata_i[CTRL_CLR_OVERRUN])
        overrun_reg <= 1'b0;
      if (ferr_set)
        ferr_reg <= 1'b1;
      else if (ctrl_wr && iob_wdata_i[CTRL_CLR_FERR])
        ferr_reg <= 1'b0;
      if (div_wr)
        div_reg <= iob_wdata_i[15:0];
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_RXDATA: begin
        if (!fifo_empty) begin
          rd_val[RX_VALID_BIT] = 1'b1;
          rd_val[7:0]          = fifo_data;
        end
      end
      REG_STATUS: begin
        rd_val[FIFO_W:0]         = fifo_count;
        rd_val[STAT_OVERRUN_BIT] = overrun_reg;
        rd_val[STAT_FERR_BIT]    = ferr_reg;
        rd_val[STAT_BUSY_BIT]    = (state_reg != ST_IDLE);
      end
      REG_DIV:  rd_val = div_reg;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (cke_i) begin
        rvalid_reg <= rd_req;
        rdata_reg  <= rd_req ? DATA_W'(rd_val) : '0;
      end
    end
  end

endmodule
